array_elem_serializer: RTL and testbench

ARRAY_ELEM_SERIALIZER -- requirements
Module: array_elem_serializer

---
 rtl/array_elem_serializer_pkg.sv | 20 ++
 rtl/array_elem_serializer_if.sv | 32 +++
 rtl/array_elem_mux.sv | 22 ++
 rtl/array_elem_serializer.sv | 118 +++++++++++
 tb/tb_array_elem_serializer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/array_elem_serializer_pkg.sv
// Shared constants and types for the array element serializer.
package array_elem_serializer_pkg;

  // Default element width and element count per array
  localparam int ELEM_W_DEF    = 33;
  localparam int NUM_ELEMS_DEF = 4;

  // Element index width for the default element count
  localparam int IDX_W = $clog2(NUM_ELEMS_DEF);

  // Width of the completed-array counter (wraps naturally)
  localparam int CNT_W = 16;

  // IDLE: no array held. SEND: array held, beats outstanding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/array_elem_serializer_if.sv
// Input array handshake, output element stream and status counter.
interface array_elem_serializer_if
  import array_elem_serializer_pkg::*;
#(
  parameter int ELEM_W    = ELEM_W_DEF,
  parameter int NUM_ELEMS = NUM_ELEMS_DEF
);
  localparam int SEL_W = $clog2(NUM_ELEMS);

  logic [ELEM_W*NUM_ELEMS-1:0] in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [ELEM_W-1:0]           out_data;
  logic [SEL_W-1:0]            out_idx;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [CNT_W-1:0]            arrays_done;

  // Producer of arrays / consumer of elements
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_last, out_valid, arrays_done
  );

  // The serializer itself
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_last, out_valid, arrays_done
  );

endinterface

// File: rtl/array_elem_mux.sv
// Combinational element select from a flattened array.
module array_elem_mux #(
  parameter int ELEM_W    = 33,
  parameter int NUM_ELEMS = 4,
  parameter int SEL_W     = $clog2(NUM_ELEMS)
) (
  input  logic [ELEM_W*NUM_ELEMS-1:0] arr_i,
  input  logic [SEL_W-1:0]            sel_i,
  output logic [ELEM_W-1:0]           elem_o
);

  // Pick element [sel_i]; NUM_ELEMS is a power of two so every code is covered
  always_comb begin
    elem_o = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      if (sel_i == SEL_W'(i)) begin
        elem_o = arr_i[ELEM_W*i +: ELEM_W];
      end
    end
  end

endmodule

// File: rtl/array_elem_serializer.sv
// Accepts a whole array in one handshake and emits its elements one per
// beat, lowest index first, with zero-bubble back-to-back arrays.
module array_elem_serializer
  import array_elem_serializer_pkg::*;
#(
  parameter int ELEM_W    = ELEM_W_DEF,
  parameter int NUM_ELEMS = NUM_ELEMS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  array_elem_serializer_if.slave  sif
);

  localparam int SEL_W = $clog2(NUM_ELEMS);
  localparam int ARR_W = ELEM_W * NUM_ELEMS;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_ELEMS - 1);

  state_e             state_q, state_d;
  logic [ARR_W-1:0]   hold_q, hold_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   arrays_done_q, arrays_done_d;

  logic               send_w;
  logic               last_w;
  logic               in_ready_w;
  logic               accept_w;
  logic               beat_w;
  logic [ELEM_W-1:0]  elem_w;

  array_elem_mux #(
    .ELEM_W    (ELEM_W),
    .NUM_ELEMS (NUM_ELEMS),
    .SEL_W     (SEL_W)
  ) u_mux (
    .arr_i  (hold_q),
    .sel_i  (idx_q),
    .elem_o (elem_w)
  );

  // Handshake qualifiers; in_ready never looks at in_valid and
  // out_valid never looks at out_ready
  always_comb begin
    send_w     = (state_q == ST_SEND);
    last_w     = (idx_q == LAST_IDX);
    in_ready_w = !send_w || (sif.out_ready && last_w);
    accept_w   = sif.in_valid && in_ready_w;
    beat_w     = send_w && sif.out_ready;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, holding register, index and counter updates
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    idx_d         = idx_q;
    arrays_done_d = arrays_done_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_w) begin
          hold_d  = sif.in_data;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (beat_w) begin
          if (!last_w) begin
            idx_d = idx_q + SEL_W'(1);
          end else begin
            arrays_done_d = arrays_done_q + CNT_W'(1);
            idx_d         = '0;
            if (accept_w) begin
              // Reload on the last beat so the next array follows without a gap
              hold_d = sif.in_data;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Holding register, element index and completed-array count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q        <= '0;
      idx_q         <= '0;
      arrays_done_q <= '0;
    end else begin
      hold_q        <= hold_d;
      idx_q         <= idx_d;
      arrays_done_q <= arrays_done_d;
    end
  end

  // Output stream is forced to zero whenever no element is being presented
  always_comb begin
    sif.in_ready    = in_ready_w;
    sif.out_valid   = send_w;
    sif.out_data    = send_w ? elem_w : '0;
    sif.out_idx     = send_w ? idx_q : '0;
    sif.out_last    = send_w && last_w;
    sif.arrays_done = arrays_done_q;
  end

endmodule

// File: tb/tb_array_elem_serializer.sv
// Scoreboard bench for array_elem_serializer: stimulus pushes expected
// beats, a negedge monitor pops and compares every transferred beat.
module tb_array_elem_serializer;

  localparam int EW = 33;
  localparam int NE = 4;
  localparam int IW = 2;
  localparam int AW = EW * NE;

  typedef struct packed {
    logic [EW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  beat_t exp_q[$];
  beat_t mon_e;

  always #5 clk = ~clk;

  array_elem_serializer_if #(.ELEM_W(EW), .NUM_ELEMS(NE)) bus ();

  array_elem_serializer #(.ELEM_W(EW), .NUM_ELEMS(NE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (bus.slave)
  );

  function automatic logic [AW-1:0] mk(input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                                       input logic [EW-1:0] e2, input logic [EW-1:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_array(input logic [AW-1:0] a);
    beat_t b;
    for (int i = 0; i < NE; i++) begin
      b.data = a[EW*i +: EW];
      b.idx  = IW'(i);
      b.last = (i == NE - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, let the accepting edge pass
  task automatic wait_accept(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    if (!bus.in_ready) check({tag, "_accept_timeout"}, 64'(k), 64'(0));
    tick();
  endtask

  // Wait (bounded) for the last beat transfer, let that edge pass
  task automatic wait_last(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!(bus.out_valid && bus.out_ready && bus.out_last) && k < 40) begin
      k++;
      @(negedge clk);
    end
    if (!(bus.out_valid && bus.out_ready && bus.out_last))
      check({tag, "_last_timeout"}, 64'(k), 64'(0));
    tick();
  endtask

  task automatic send_full(input logic [AW-1:0] a, input string tag);
    bus.in_data  = a;
    bus.in_valid = 1'b1;
    push_array(a);
    wait_accept(tag);
    bus.in_valid = 1'b0;
    wait_last(tag);
  endtask

  // Scoreboard monitor: compare every transferred beat against the queue head
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL beat_unexpected: got idx %0d data %0h expected no beat", bus.out_idx, bus.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", 64'(bus.out_data), 64'(mon_e.data));
        check("beat_idx", 64'(bus.out_idx), 64'(mon_e.idx));
        check("beat_last", 64'(bus.out_last), 64'(mon_e.last));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [AW-1:0] arr_a, arr_b, arr_c, arr_d, arr_e, arr_f, arr_g, arr_x;

  initial begin
    arr_a = mk(33'h0_0000_000A, 33'h0_0000_002A, 33'h1_0000_0003, 33'h1_FFFF_FFFF);
    arr_b = mk(33'h0_1111_1111, 33'h1_2222_2222, 33'h0_3333_3333, 33'h1_4444_4444);
    arr_c = mk(33'h0_0000_0C00, 33'h1_0000_0C01, 33'h0_DEAD_BEEF, 33'h1_0000_0C03);
    arr_d = mk(33'h0_0000_0D00, 33'h0_0000_0D01, 33'h0_0000_0D02, 33'h0_0000_0D03);
    arr_e = mk(33'h1_AAAA_5555, 33'h0_5555_AAAA, 33'h1_0F0F_0F0F, 33'h0_F0F0_F0F0);
    arr_f = mk(33'h0_0000_0F00, 33'h0_0000_0F01, 33'h0_0000_0F02, 33'h0_0000_0F03);
    arr_g = mk(33'h1_0000_0000, 33'h0_0000_0001, 33'h1_8000_0000, 33'h0_7FFF_FFFF);
    arr_x = mk(33'h1_BAD0_BAD0, 33'h1_BAD1_BAD1, 33'h1_BAD2_BAD2, 33'h1_BAD3_BAD3);

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    tick();
    tick();

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_idx", 64'(bus.out_idx), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_arrays_done", 64'(bus.arrays_done), 64'd0);
    tick();
    rst_n = 1'b1;

    // Idle stability
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_out_valid", 64'(bus.out_valid), 64'd0);
      check("idle_in_ready", 64'(bus.in_ready), 64'd1);
      check("idle_arrays_done", 64'(bus.arrays_done), 64'd0);
      tick();
    end

    // Single array, exact timing
    bus.in_data  = arr_a;
    bus.in_valid = 1'b1;
    push_array(arr_a);
    @(negedge clk);
    check("single_in_ready", 64'(bus.in_ready), 64'd1);
    check("single_pre_valid", 64'(bus.out_valid), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < NE; c++) begin
      @(negedge clk);
      check("single_valid", 64'(bus.out_valid), 64'd1);
      check("single_idx", 64'(bus.out_idx), 64'(c));
      check("single_last", 64'(bus.out_last), 64'(c == NE - 1));
      tick();
    end
    @(negedge clk);
    check("single_post_valid", 64'(bus.out_valid), 64'd0);
    check("single_done", 64'(bus.arrays_done), 64'd1);
    check("single_post_in_ready", 64'(bus.in_ready), 64'd1);
    tick();

    // Back-to-back arrays with in_valid held high
    bus.in_data  = arr_a;
    bus.in_valid = 1'b1;
    push_array(arr_a);
    tick();
    bus.in_data = arr_b;
    push_array(arr_b);
    for (int c = 0; c < 2 * NE; c++) begin
      @(negedge clk);
      check("b2b_valid", 64'(bus.out_valid), 64'd1);
      check("b2b_in_ready", 64'(bus.in_ready), 64'((c % NE) == NE - 1));
      tick();
      if (c == NE - 1) bus.in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_post_valid", 64'(bus.out_valid), 64'd0);
    check("b2b_done", 64'(bus.arrays_done), 64'd3);
    tick();

    // Backpressure at idx 1
    bus.in_data  = arr_c;
    bus.in_valid = 1'b1;
    push_array(arr_c);
    wait_accept("bp");
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    bus.in_data   = arr_x;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_idx", 64'(bus.out_idx), 64'd1);
      check("bp_data", 64'(bus.out_data), 64'(33'h1_0000_0C01));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_idx", 64'(bus.out_idx), 64'd1);
    check("bp_resume_data", 64'(bus.out_data), 64'(33'h1_0000_0C01));
    tick();
    wait_last("bp");
    @(negedge clk);
    check("bp_done", 64'(bus.arrays_done), 64'd4);
    tick();

    // Reset after idx 2 transferred
    bus.in_data  = arr_d;
    bus.in_valid = 1'b1;
    push_array(arr_d);
    wait_accept("rst_mid");
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rstmid_done", 64'(bus.arrays_done), 64'd0);
    check("rstmid_out_data", 64'(bus.out_data), 64'd0);
    check("rstmid_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.out_ready = 1'b1;
    bus.in_data   = arr_e;
    bus.in_valid  = 1'b1;
    push_array(arr_e);
    wait_accept("rst_next");
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rstmid_next_idx", 64'(bus.out_idx), 64'd0);
    check("rstmid_next_valid", 64'(bus.out_valid), 64'd1);
    tick();
    wait_last("rst_next");
    @(negedge clk);
    check("rstmid_next_done", 64'(bus.arrays_done), 64'd1);

    // Counter wrap via preload
    force dut.arrays_done_q = 16'hFFFE;
    #1;
    release dut.arrays_done_q;
    tick();
    send_full(arr_f, "wrap1");
    @(negedge clk);
    check("wrap_ffff", 64'(bus.arrays_done), 64'hFFFF);
    tick();
    send_full(arr_g, "wrap2");
    @(negedge clk);
    check("wrap_zero", 64'(bus.arrays_done), 64'h0000);
    tick();

    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
